// File: rtl/ans_encoder.sv
// rtl/ans_encoder.sv - streaming rANS encoder: renormalise, divide, update, flush
// Emits nibbles in encode order; the decoder consumes them reversed (LIFO).
module ans_encoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int SYM_COUNT   = 16,
   parameter int CNT_WIDTH   = 8,
   parameter int STATE_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic [SYM_WIDTH-1:0]           in,
   input  logic                           in_last,
   input  logic                           in_vld,
   output logic                           in_rdy,
   input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
   output logic [SYM_WIDTH-1:0]           out,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic                           out_last,
   output logic                           err
);

   localparam int SHIFT = STATE_WIDTH - CNT_WIDTH;
   localparam int NIB   = STATE_WIDTH / SYM_WIDTH;
   localparam int DCW   = $clog2(STATE_WIDTH);
   localparam int FCW   = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [STATE_WIDTH-1:0] L_VAL = STATE_WIDTH'(1) << (STATE_WIDTH - 4);

   typedef enum logic [2:0] {S_IDLE, S_RENORM, S_DIVIDE, S_UPDATE, S_FLUSH} state_t;

   state_t                 r_state;
   logic [STATE_WIDTH-1:0] r_x;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [CNT_WIDTH-1:0]   r_cum;
   logic                   r_last;
   logic [CNT_WIDTH-1:0]   r_rem;
   logic [STATE_WIDTH-1:0] r_quo;
   logic [DCW-1:0]         r_div_cnt;
   logic [FCW-1:0]         r_fl_cnt;
   logic                   r_in_rdy;
   logic [SYM_WIDTH-1:0]   r_out;
   logic                   r_out_vld;
   logic                   r_out_last;
   logic                   r_err;

   logic [CNT_WIDTH-1:0]   w_cnt_tab [SYM_COUNT];
   logic [CNT_WIDTH-1:0]   w_cum_tab [SYM_COUNT];
   logic [CNT_WIDTH-1:0]   w_cnt_in;
   logic [CNT_WIDTH-1:0]   w_cum_in;
   logic [STATE_WIDTH-1:0] w_thr;
   logic [STATE_WIDTH-1:0] w_x_shr;
   logic                   w_emit;
   logic                   w_shr_emit;
   logic [CNT_WIDTH:0]     w_rem_sh;
   logic [CNT_WIDTH:0]     w_rem_sub;
   logic                   w_rem_ge;
   logic [CNT_WIDTH-1:0]   w_rem_nxt;
   logic [STATE_WIDTH-1:0] w_x_upd;

   // Exclusive prefix sum of the frequency table, wrapped to CNT_WIDTH bits.
   always_comb begin
      logic [CNT_WIDTH-1:0] v_acc;
      v_acc = '0;
      for (int i = 0; i < SYM_COUNT; i++) begin
         w_cnt_tab[i] = counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
         w_cum_tab[i] = v_acc;
         v_acc        = v_acc + counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
      end
   end

   assign w_cnt_in   = w_cnt_tab[in];
   assign w_cum_in   = w_cum_tab[in];
   assign w_thr      = {r_cnt, {SHIFT{1'b0}}};
   assign w_x_shr    = r_x >> SYM_WIDTH;
   assign w_emit     = r_x >= w_thr;
   assign w_shr_emit = w_x_shr >= w_thr;
   assign w_rem_sh   = {r_rem, r_quo[STATE_WIDTH-1]};
   assign w_rem_sub  = w_rem_sh - {1'b0, r_cnt};
   assign w_rem_ge   = w_rem_sh >= {1'b0, r_cnt};
   assign w_rem_nxt  = w_rem_ge ? w_rem_sub[CNT_WIDTH-1:0] : w_rem_sh[CNT_WIDTH-1:0];
   assign w_x_upd    = (r_quo << CNT_WIDTH) + STATE_WIDTH'(r_rem) + STATE_WIDTH'(r_cum);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_x        <= L_VAL;
         r_cnt      <= '0;
         r_cum      <= '0;
         r_last     <= 1'b0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_div_cnt  <= '0;
         r_fl_cnt   <= '0;
         r_in_rdy   <= 1'b1;
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
         r_err      <= 1'b0;
      end else if (en) begin
         case (r_state)
            S_IDLE: if (in_vld) begin
               if (w_cnt_in == '0) begin
                  r_err <= 1'b1;
                  if (in_last) begin
                     r_state    <= S_FLUSH;
                     r_in_rdy   <= 1'b0;
                     r_out      <= r_x[STATE_WIDTH-1 -: SYM_WIDTH];
                     r_out_vld  <= 1'b1;
                     r_out_last <= (NIB == 1);
                     r_fl_cnt   <= '0;
                  end
               end else begin
                  r_cnt    <= w_cnt_in;
                  r_cum    <= w_cum_in;
                  r_last   <= in_last;
                  r_in_rdy <= 1'b0;
                  r_state  <= S_RENORM;
               end
            end
            S_RENORM: if (!r_out_vld) begin
               if (w_emit) begin
                  r_out     <= r_x[SYM_WIDTH-1:0];
                  r_out_vld <= 1'b1;
               end else begin
                  r_quo     <= r_x;
                  r_rem     <= '0;
                  r_div_cnt <= '0;
                  r_state   <= S_DIVIDE;
               end
            end else if (out_rdy) begin
               // Look ahead at the shifted state so back-to-back nibbles need no bubble.
               r_x <= w_x_shr;
               if (w_shr_emit) begin
                  r_out <= w_x_shr[SYM_WIDTH-1:0];
               end else begin
                  r_out     <= '0;
                  r_out_vld <= 1'b0;
                  r_quo     <= w_x_shr;
                  r_rem     <= '0;
                  r_div_cnt <= '0;
                  r_state   <= S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               r_rem     <= w_rem_nxt;
               r_quo     <= {r_quo[STATE_WIDTH-2:0], w_rem_ge};
               r_div_cnt <= r_div_cnt + 1'b1;
               if (r_div_cnt == DCW'(STATE_WIDTH - 1)) r_state <= S_UPDATE;
            end
            S_UPDATE: begin
               r_x <= w_x_upd;
               if (r_last) begin
                  r_state    <= S_FLUSH;
                  r_out      <= w_x_upd[STATE_WIDTH-1 -: SYM_WIDTH];
                  r_out_vld  <= 1'b1;
                  r_out_last <= (NIB == 1);
                  r_fl_cnt   <= '0;
               end else begin
                  r_state  <= S_IDLE;
                  r_in_rdy <= 1'b1;
               end
            end
            S_FLUSH: if (out_rdy) begin
               // x is discarded after the flush, so it doubles as the nibble shift register.
               if (r_out_last) begin
                  r_x        <= L_VAL;
                  r_out      <= '0;
                  r_out_vld  <= 1'b0;
                  r_out_last <= 1'b0;
                  r_in_rdy   <= 1'b1;
                  r_state    <= S_IDLE;
               end else begin
                  r_x        <= r_x << SYM_WIDTH;
                  r_out      <= r_x[STATE_WIDTH-SYM_WIDTH-1 -: SYM_WIDTH];
                  r_fl_cnt   <= r_fl_cnt + 1'b1;
                  r_out_last <= (r_fl_cnt == FCW'(NIB - 2));
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_rdy   = r_in_rdy;
   assign out      = r_out;
   assign out_vld  = r_out_vld;
   assign out_last = r_out_last;
   assign err      = r_err;

endmodule

// File: tb/tb_ans_encoder.sv
// tb/tb_ans_encoder.sv - randomized self-checking bench for ans_encoder
module tb_ans_encoder;
   localparam int SW  = 4;
   localparam int SC  = 16;
   localparam int CW  = 8;
   localparam int STW = 16;
   localparam int NIB = STW / SW;
   localparam int LV  = 1 << (STW - 4);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [SW-1:0]   s_in;
   logic            s_last;
   logic            in_vld;
   logic            in_rdy;
   logic [CW*SC-1:0] counts_unpacked;
   logic [SW-1:0]   out;
   logic            out_vld;
   logic            out_rdy;
   logic            out_last;
   logic            err;

   int errors = 0;
   int checks = 0;
   int m_cnt [SC];
   int m_x;
   bit m_err;
   int syms [$];
   logic [4:0] exp_q [$];
   logic [4:0] got_q [$];
   bit rand_rdy = 1'b0;
   int last_wait;

   ans_encoder #(.SYM_WIDTH(SW), .SYM_COUNT(SC), .CNT_WIDTH(CW), .STATE_WIDTH(STW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in(s_in), .in_last(s_last), .in_vld(in_vld),
      .in_rdy(in_rdy), .counts_unpacked(counts_unpacked), .out(out), .out_vld(out_vld),
      .out_rdy(out_rdy), .out_last(out_last), .err(err));

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && en && out_vld && out_rdy) got_q.push_back({out_last, out});

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
   end

   function automatic string q2s(input logic [4:0] q [$]);
      string s, t;
      s = "";
      foreach (q[k]) begin
         if (q[k][4]) t = "*"; else t = "-";
         s = $sformatf("%s%h%s ", s, q[k][3:0], t);
      end
      return s;
   endfunction

   function automatic int cum_of(int s);
      int c = 0;
      for (int i = 0; i < s; i++) c += m_cnt[i];
      return c % (1 << CW);
   endfunction

   task automatic set_counts();
      for (int i = 0; i < SC; i++) counts_unpacked[i*CW +: CW] = CW'(m_cnt[i]);
   endtask

   task automatic set_uniform();
      for (int i = 0; i < SC; i++) m_cnt[i] = 16;
      set_counts();
   endtask

   task automatic set_skewed();
      for (int i = 0; i < SC; i++) m_cnt[i] = 1;
      m_cnt[0] = 241;
      set_counts();
   endtask

   // rANS reference: renormalise, then x' = floor(x/f)*M + x%f + cum.
   task automatic model_sym(int s);
      int c;
      c = m_cnt[s];
      if (c == 0) begin
         m_err = 1'b1;
         return;
      end
      while (m_x >= c * (1 << (STW - CW))) begin
         exp_q.push_back({1'b0, 4'(m_x % 16)});
         m_x = m_x / 16;
      end
      m_x = ((m_x / c) * (1 << CW) + (m_x % c) + cum_of(s)) % (1 << STW);
   endtask

   task automatic model_flush();
      for (int k = NIB - 1; k >= 0; k--) exp_q.push_back({(k == 0), 4'((m_x >> (4 * k)) % 16)});
      m_x = LV;
   endtask

   task automatic send(input int s, input bit last, output int waited);
      s_in = 4'(s);
      s_last = last;
      in_vld = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_rdy && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!in_rdy) begin
         errors++;
         $display("FAIL send_accept in_rdy=%b required 1 within 3000 cycles", in_rdy);
      end
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!(got_q.size() >= exp_q.size() && in_rdy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL block_done got %0d nibbles required %0d, in_rdy=%b", got_q.size(), exp_q.size(), in_rdy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_block();
      int w;
      exp_q = {};
      got_q = {};
      foreach (syms[k]) model_sym(syms[k]);
      model_flush();
      foreach (syms[k]) begin
         send(syms[k], (k == syms.size() - 1), w);
         if (k == 0) last_wait = w;
      end
      wait_done();
   endtask

   task automatic measure_latency(input bit pulse_en, output int n);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (in_rdy) break;
         @(posedge clk);
         n++;
         #1;
         if (pulse_en && n == 6) en = 1'b0;
         if (pulse_en && n == 11) en = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; s_in = '0; s_last = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
      set_uniform();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_rdy !== 1'b1)   begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
      checks++; if (out_vld !== 1'b0)  begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
      checks++; if (out !== 4'h0)      begin errors++; $display("FAIL reset_out got %h want 0", out); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got %b want 0", err); end
      rst_n = 1'b1;
      m_x = LV;
      m_err = 1'b0;
   endtask

   task automatic test_uniform();
      set_uniform();
      for (int r = 0; r < 2; r++) begin
         syms = {};
         syms.push_back(5);
         run_block();
         if (r == 0) begin
            checks++;
            if (last_wait !== 0) begin errors++; $display("FAIL first_accept waited %0d cycles want 0", last_wait); end
         end
         checks++;
         if (q2s(got_q) != "0- 1- 0- 5- 0* ") begin
            errors++; $display("FAIL uniform_stream_%0d got '%s' want '0- 1- 0- 5- 0* '", r, q2s(got_q));
         end
      end
   endtask

   task automatic test_skewed();
      set_skewed();
      syms = {};
      syms.push_back(3);
      run_block();
      checks++;
      if (q2s(got_q) != "0- 0- 1- 0- f- 3* ") begin
         errors++; $display("FAIL skewed_stream got '%s' want '0- 0- 1- 0- f- 3* '", q2s(got_q));
      end
   endtask

   task automatic test_stall();
      int w, n;
      set_uniform();
      exp_q = {};
      got_q = {};
      model_sym(5);
      model_flush();
      out_rdy = 1'b0;
      send(5, 1'b1, w);
      n = 0;
      @(negedge clk);
      while (!out_vld && n < 50) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (out_vld !== 1'b1 || out !== 4'h0 || out_last !== 1'b0) begin
            errors++; $display("FAIL stall_hold cycle %0d got vld=%b out=%h last=%b want 1/0/0", i, out_vld, out, out_last);
         end
      end
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      wait_done();
      checks++;
      if (q2s(got_q) != "0- 1- 0- 5- 0* ") begin
         errors++; $display("FAIL stall_stream got '%s' want '0- 1- 0- 5- 0* '", q2s(got_q));
      end
   endtask

   task automatic test_zero_count();
      int w;
      for (int i = 0; i < SC; i++) m_cnt[i] = 16;
      m_cnt[7] = 0;
      m_cnt[0] = 32;
      set_counts();
      exp_q = {};
      got_q = {};
      send(7, 1'b0, w);
      m_err = 1'b1;
      @(negedge clk);
      checks++; if (err !== 1'b1)     begin errors++; $display("FAIL zero_err got %b want 1", err); end
      checks++; if (in_rdy !== 1'b1)  begin errors++; $display("FAIL zero_in_rdy got %b want 1", in_rdy); end
      checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL zero_out_vld got %b want 0", out_vld); end
      @(posedge clk);
      #1;
      syms = {};
      syms.push_back(5);
      run_block();
      checks++;
      if (q2s(got_q) != q2s(exp_q)) begin
         errors++; $display("FAIL zero_followup got '%s' want '%s'", q2s(got_q), q2s(exp_q));
      end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL zero_err_sticky got %b want 1", err); end
   endtask

   task automatic test_reset_mid_divide();
      int w;
      set_uniform();
      send(5, 1'b1, w);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (in_rdy !== 1'b1)   begin errors++; $display("FAIL midrst_in_rdy got %b want 1", in_rdy); end
      checks++; if (out_vld !== 1'b0)  begin errors++; $display("FAIL midrst_out_vld got %b want 0", out_vld); end
      checks++; if (err !== 1'b0)      begin errors++; $display("FAIL midrst_err got %b want 0", err); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL midrst_out_last got %b want 0", out_last); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_x = LV;
      m_err = 1'b0;
      syms = {};
      syms.push_back(5);
      run_block();
      checks++;
      if (q2s(got_q) != "0- 1- 0- 5- 0* ") begin
         errors++; $display("FAIL midrst_stream got '%s' want '0- 1- 0- 5- 0* '", q2s(got_q));
      end
   endtask

   task automatic test_latency(input bit pulse_en);
      int w, n, want;
      want = pulse_en ? STW + 7 : STW + 2;
      set_skewed();
      exp_q = {};
      got_q = {};
      model_sym(0);
      send(0, 1'b0, w);
      measure_latency(pulse_en, n);
      checks++;
      if (n !== want) begin errors++; $display("FAIL latency_en%0d got %0d cycles want %0d", pulse_en, n, want); end
      checks++;
      if (got_q.size() !== 0) begin errors++; $display("FAIL latency_no_output_en%0d got %0d nibbles want 0", pulse_en, got_q.size()); end
      syms = {};
      syms.push_back(3);
      run_block();
      checks++;
      if (q2s(got_q) != q2s(exp_q)) begin
         errors++; $display("FAIL latency_state_en%0d got '%s' want '%s'", pulse_en, q2s(got_q), q2s(exp_q));
      end
   endtask

   task automatic test_random();
      bit ex [SC];
      int s, len;
      for (int b = 0; b < 12; b++) begin
         for (int i = 0; i < SC; i++) begin m_cnt[i] = 0; ex[i] = 1'b0; end
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) ex[$urandom_range(0, SC - 1)] = 1'b1;
         for (int u = 0; u < (1 << CW); u++) begin
            s = $urandom_range(0, SC - 1);
            while (ex[s] || m_cnt[s] >= 255) s = $urandom_range(0, SC - 1);
            m_cnt[s]++;
         end
         set_counts();
         syms = {};
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) syms.push_back($urandom_range(0, SC - 1));
         rand_rdy = 1'b1;
         run_block();
         rand_rdy = 1'b0;
         out_rdy = 1'b1;
         checks++;
         if (q2s(got_q) != q2s(exp_q)) begin
            errors++; $display("FAIL random_stream blk %0d got '%s' want '%s'", b, q2s(got_q), q2s(exp_q));
         end
         checks++;
         if (err !== m_err) begin errors++; $display("FAIL random_err blk %0d got %b want %b", b, err, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_skewed();
      test_stall();
      test_zero_count();
      test_reset_mid_divide();
      test_latency(1'b0);
      test_latency(1'b1);
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ans_encoder.md
ANS_ENCODER -- requirements
Module: ans_encoder

Interface
REQ-001 Parameter SYM_WIDTH, default 4: symbol and output nibble width.
REQ-002 Parameter SYM_COUNT, default 16: alphabet size.
REQ-003 Parameter CNT_WIDTH, default 8: frequency width; table total M = 2^CNT_WIDTH.
REQ-004 Parameter STATE_WIDTH, default 16: coder state width; lower bound L = 2^(STATE_WIDTH-4).
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port en, input, 1: global enable; when 0 all registers hold and no transfer occurs.
REQ-008 Port in, input, SYM_WIDTH: symbol to encode.
REQ-009 Port in_last, input, 1: marks final symbol of a block; sampled with in.
REQ-010 Port in_vld / in_rdy, input / output, 1 each: input handshake; transfer when both high and en=1.
REQ-011 Port counts_unpacked, input, CNT_WIDTH*SYM_COUNT: counts[i] = bits [i*CNT_WIDTH +: CNT_WIDTH]; static during a block; sum equals M.
REQ-012 Port out, output, SYM_WIDTH: emitted stream nibble.
REQ-013 Port out_vld / out_rdy, output / input, 1 each: output handshake; transfer when both high and en=1.
REQ-014 Port out_last, output, 1: high with the final flush nibble of a block.
REQ-015 Port err, output, 1: sticky flag, set when a symbol with count 0 is accepted.

Function
REQ-016 cum[s] SHALL equal sum of counts[0..s-1], computed combinationally, CNT_WIDTH bits.
REQ-017 States: IDLE, RENORM, DIVIDE, UPDATE, FLUSH; in_rdy SHALL be 1 only in IDLE.
REQ-018 IDLE, on input transfer: latch symbol, counts[in], cum[in], in_last; go RENORM.
REQ-019 IDLE, accepted symbol with count 0: set err, drop symbol (state x unchanged); go FLUSH if in_last else stay IDLE.
REQ-020 RENORM: while x >= counts[s] << (STATE_WIDTH-CNT_WIDTH), present out = x[3:0], out_vld = 1; on out transfer x <= x >> 4; comparison re-evaluated next cycle; else go DIVIDE.
REQ-021 DIVIDE: restoring divider, x / counts[s], exactly STATE_WIDTH cycles, producing quotient q and remainder r.
REQ-022 UPDATE (1 cycle): x <= (q << CNT_WIDTH) + r + cum[s], truncated to STATE_WIDTH; go FLUSH if latched last else IDLE.
REQ-023 Latency: with no renorm nibbles, in_rdy SHALL be high again exactly STATE_WIDTH+2 cycles after the accepting edge.
REQ-024 FLUSH: emit STATE_WIDTH/4 nibbles of x, most-significant first; out_last = 1 on the last one; after its transfer x <= L, go IDLE.
REQ-025 out and out_last SHALL hold stable while out_vld = 1 and out_rdy = 0; out_vld SHALL drop the cycle after the transfer unless another nibble follows.
REQ-026 Stream is LIFO w.r.t. the decoder; nibble reversal is downstream of this block.
REQ-027 Renorm emits at most (STATE_WIDTH-CNT_WIDTH)/4 nibbles per symbol; x SHALL stay in [L, 2^STATE_WIDTH) after every UPDATE.

Reset
REQ-028 On rst_n low: state IDLE, x = L, in_rdy = 1, out_vld = 0, out = 0, out_last = 0, err = 0, divider cleared; applies immediately, including mid-DIVIDE or mid-FLUSH.
REQ-029 First input transfer can occur on the first enabled edge after rst_n rises.

Verification
REQ-030 Uniform counts (16 each), x = 0x1000, send sym 5 with in_last, out_rdy = 1 -> out nibbles 0x0, then 0x1, 0x0, 0x5, 0x0, out_last only on the final; x returns to 0x1000.
REQ-031 counts[0] = 241, counts[1..15] = 1, send sym 3 with in_last -> nibbles 0x0, 0x0, then 0x1, 0x0, 0xF, 0x3 with out_last.
REQ-032 Uniform counts, sym 5, out_rdy held 0 for 10 cycles -> out = 0x0, out_vld = 1 held stable, x unchanged, until out_rdy rises.
REQ-033 counts[7] = 0, send sym 7 without in_last -> err = 1, no output, in_rdy high next cycle, x unchanged.
REQ-034 rst_n pulsed low mid-DIVIDE -> in_rdy = 1, out_vld = 0, err = 0 immediately; next block reproduces REQ-030 output.
REQ-035 en = 0 for 5 cycles mid-DIVIDE -> in_rdy rises exactly 5 cycles later than REQ-023 latency; output unchanged.
